mem_stage: RTL

- Pipeline MEM stage. Consumes the EX/MEM register contents and runs the data-memory access over a req/ack handshake.
- Implements LL/SC reservation, byte-lane alignment and load extension, and branch/jump/jr redirect.
- Registers results into the MEM/WB register and drives stall_out to the hazard unit while an access is outstanding.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_align.sv | 36 +++
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage.
// Provides the access FSM state, access-width masks and the link register index.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Bytes are always aligned; halves need addr[0]==0; words need addr[1:0]==0.
    function automatic logic is_aligned(input logic [3:0] mask,
                                        input logic [1:0] lo);
        return (mask == MASK_B) ||
               (mask == MASK_H && !lo[0]) ||
               (lo == 2'b00);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the MEM stage.
// Ports: addr_lo/mask/rt_data/rdata/zero_ext in; be, wdata, load_data out.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  mask,
    input  logic [31:0] rt_data,
    input  logic [31:0] rdata,
    input  logic        zero_ext,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign be      = mask << addr_lo;
    assign wdata   = rt_data << {addr_lo, 3'b000};
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        unique case (1'b1)
            mask == MASK_B:
                load_data = zero_ext ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            mask == MASK_H:
                load_data = zero_ext ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default:
                load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory req/ack access, LL/SC, load extension, redirect.
// Ports: EX/MEM inputs, dmem_* bus, stall/redirect/error, MEM/WB register outputs.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic        regDst_in,
    input  logic        regWrite_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        memToReg_in,
    input  logic        atomic_in,
    input  logic        jal_in,
    input  logic        jr_in,
    input  logic [3:0]  mMask_in,
    input  logic [31:0] rsData_in,
    input  logic [31:0] rtData_in,
    input  logic [31:0] aluRes_in,
    input  logic [31:0] branchTarget_in,
    input  logic [31:0] jumpTarget_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        redirect_out,
    output logic [31:0] redirect_target_out,
    output logic        mem_err_out,
    output logic        regWrite_out,
    output logic        memToReg_out,
    output logic [4:0]  writeReg_out,
    output logic [31:0] aluRes_out,
    output logic [31:0] memData_out,
    output logic [31:0] pc_out
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    mem_state_t  state, state_n;
    logic        issue, ack_hit, to_hit, timeout;
    logic [31:0] cnt;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        res_valid;
    logic [29:0] res_addr;

    logic        is_mem, aligned, misaligned;
    logic        is_ll, is_sc, res_hit, sc_fail, mem_op;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;

    logic        unused_ok;
    assign unused_ok = ^{instruction_in[31:29], instruction_in[27:21],
                         instruction_in[10:0]};

    assign is_mem     = memRead_in | memWrite_in;
    assign aligned    = is_aligned(mMask_in, aluRes_in[1:0]);
    assign misaligned = is_mem & ~aligned;
    assign is_ll      = atomic_in & memRead_in;
    assign is_sc      = atomic_in & memWrite_in;
    assign res_hit    = res_valid && (res_addr == aluRes_in[31:2]);
    assign sc_fail    = is_sc & aligned & ~res_hit;
    assign mem_op     = is_mem & aligned & ~(is_sc & ~res_hit);

    assign stall_out  = mem_op & (state != RESP);
    assign timeout    = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    // Misalignment flags while the instruction is present; a timeout
    // flags during the RESP cycle that retires it.
    assign mem_err_out = misaligned | ((state == RESP) & err_q);

    assign redirect_out = (branch_in | jump_in | jr_in) & ~stall_out;
    assign redirect_target_out = jr_in   ? rsData_in :
                                 jump_in ? jumpTarget_in :
                                           branchTarget_in;

    mem_align u_align (
        .addr_lo  (aluRes_in[1:0]),
        .mask     (mMask_in),
        .rt_data  (rtData_in),
        .rdata    (rdata_q),
        .zero_ext (instruction_in[28]),
        .be       (al_be),
        .wdata    (al_wdata),
        .load_data(al_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        ack_hit = 1'b0;
        to_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_n = WAIT;
                    issue   = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_n = RESP;
                    ack_hit = 1'b1;
                end else if (timeout) begin
                    state_n = RESP;
                    to_hit  = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus request and its held payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            dmem_req <= (state_n == WAIT);
            if (issue) begin
                dmem_we    <= memWrite_in;
                dmem_addr  <= {aluRes_in[31:2], 2'b00};
                dmem_be    <= al_be;
                dmem_wdata <= al_wdata;
            end
            cnt   <= (state == WAIT) ? cnt + 32'd1 : 32'd0;
            err_q <= to_hit;
            if (ack_hit) rdata_q <= dmem_rdata;
        end
    end

    // Reservation: set by a completed LL, cleared by any SC or a
    // completed store to the reserved word; untouched by a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_addr  <= '0;
        end else if (state == RESP && !err_q) begin
            if (is_ll) begin
                res_valid <= 1'b1;
                res_addr  <= aluRes_in[31:2];
            end else if (memWrite_in && (is_sc || res_hit)) begin
                res_valid <= 1'b0;
            end
        end else if (state == IDLE && sc_fail) begin
            res_valid <= 1'b0;
        end
    end

    // MEM/WB register; a stalled cycle loads a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite_out <= 1'b0;
            memToReg_out <= 1'b0;
            writeReg_out <= '0;
            aluRes_out   <= '0;
            memData_out  <= '0;
            pc_out       <= '0;
        end else if (stall_out) begin
            regWrite_out <= 1'b0;
        end else begin
            regWrite_out <= regWrite_in & ~misaligned &
                            ~((state == RESP) & err_q);
            memToReg_out <= memToReg_in;
            writeReg_out <= jal_in    ? LINK_REG :
                            regDst_in ? instruction_in[15:11] :
                                        instruction_in[20:16];
            aluRes_out   <= jal_in ? pc_in + 32'd4 :
                            is_sc  ? {31'b0, res_hit} :
                                     aluRes_in;
            memData_out  <= al_load;
            pc_out       <= pc_in;
        end
    end

endmodule
